uart_std_rx: RTL and testbench
==============================

# uart_std_rx

UART receiver for the standard console port: oversamples the asynchronous `io_uartStd_rxd` pin, deframes 8N1 characters and buffers them in a small FIFO behind a valid/ready stream. It sits between the board-level rxd pad and the SoC peripheral bus adapter, the receive counterpart of the console transmitter driving `io_uartStd_txd`.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per bit (100 MHz / 115200); must be ≥ 8.
- `DATA_BITS`, 8: data bits per frame, LSB first, no parity, one stop bit.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, ≥ 2.
- `io_clock`  in  1  sole clock.
- `io_reset`  in  1  synchronous, active-low reset.
- `io_uartStd_rxd`  in  1  asynchronous serial input, idle high.
- `io_rx_valid`  out  1  FIFO non-empty.
- `io_rx_ready`  in  1  consumer accepts head entry.
- `io_rx_payload`  out  DATA_BITS  FIFO head character.
- `io_occupancy`  out  clog2(FIFO_DEPTH)+1  entries held.
- `io_frameError`  out  1  one-cycle pulse: stop bit sampled low.
- `io_overrun`  out  1  sticky: character dropped because FIFO full.
- `io_clearErrors`  in  1  clears `io_overrun`.

## Operation
- Synchronizer: two flops on rxd, both reset to 1; all logic uses the second flop (`rxs`).
- Bit counter: `cnt`, width clog2(CLKS_PER_BIT); HALF = CLKS_PER_BIT/2 (integer).
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: `rxs`==0 → START, `cnt`=0.
  - START: increment `cnt`; at `cnt`==HALF-1 sample: `rxs`==0 → DATA, `cnt`=0, bit index=0; `rxs`==1 → glitch, IDLE, nothing reported.
  - DATA: at `cnt`==CLKS_PER_BIT-1 shift `rxs` into MSB of shift register (LSB-first reception), `cnt`=0, bit index+1; after bit DATA_BITS-1 → STOP.
  - STOP: at `cnt`==CLKS_PER_BIT-1 sample: `rxs`==1 → push shift register, → IDLE; `rxs`==0 → pulse `io_frameError`, discard, → BREAK.
  - BREAK: stay until `rxs`==1, then IDLE (a held-low line yields exactly one frame error).
- FIFO: pointers one bit wider than index; wrap modulo FIFO_DEPTH; `io_payload` = head entry (first-word fall-through).
  - Pop when `io_rx_valid`&&`io_rx_ready`.
  - Push when FIFO not full, or full with a pop in the same cycle (push and pop both take effect, occupancy unchanged).
  - Push when full without a pop: character dropped, `io_overrun` set; stored data unchanged.
  - Simultaneous push/pop when empty: push only (no valid yet), occupancy 0→1.
- `io_clearErrors` clears `io_overrun`; if an overrun occurs in the same cycle, set wins.
- Reset: FSM IDLE, `cnt`=0, pointers 0, shift register 0.

## Timing
- Reset values: `io_rx_valid`=0, `io_rx_payload`=0, `io_occupancy`=0, `io_frameError`=0, `io_overrun`=0.
- Pin-to-`rxs` latency: 2 cycles.
- Start sample: HALF cycles after entering START; each data/stop sample exactly CLKS_PER_BIT cycles after the previous one.
- `io_rx_valid` rises the cycle after the stop-bit sample cycle when the FIFO was empty; `io_occupancy` updates in the same cycle.
- Back-to-back frames: the receiver returns to IDLE at the stop-bit midpoint and accepts a start edge arriving within half a bit.
- `io_frameError` is high for exactly the cycle after the failing stop sample.
- Reset asserted mid-frame: partial character lost, no error flags; reception resumes on the next falling edge after reset release.
- `io_rx_ready` may be held high permanently; `io_payload` is stable while `io_rx_valid`=1 and `io_rx_ready`=0.

## Test plan
- CLKS_PER_BIT=16: send 0x55 then 0xA3 with `io_rx_ready`=1 → two single-cycle valid beats with payload 0x55, 0xA3; no error flags.
- `io_rx_ready`=0: send 5 characters 0x01..0x05 with FIFO_DEPTH=4 → occupancy 4, `io_overrun`=1; draining yields 0x01..0x04; `io_clearErrors` → `io_overrun`=0.
- Stop bit forced low on 0x7E, then line held low 40 bit-times → one `io_frameError` pulse, no push; the next valid frame 0x42 is received.
- 4-cycle low glitch on idle line → FSM returns to IDLE; no valid, no error.
- FIFO full; a stop sample coincides with a pop → occupancy stays 4, no overrun, new character at the tail.
- Assert `io_reset` low for one cycle during DATA bit 3 → all outputs reset; a subsequent 0xC6 frame is received correctly.

Source files
------------

// File: rtl/uart_std_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling deframer and a small
// first-word-fall-through FIFO presented as a valid/ready stream.
module uart_std_rx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          io_clock,
    input  logic                          io_reset,
    input  logic                          io_uartStd_rxd,
    output logic                          io_rx_valid,
    input  logic                          io_rx_ready,
    output logic [DATA_BITS-1:0]          io_rx_payload,
    output logic [$clog2(FIFO_DEPTH):0]   io_occupancy,
    output logic                          io_frameError,
    output logic                          io_overrun,
    input  logic                          io_clearErrors
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] HalfM1  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BitM1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    logic                 rx_meta_q, rxs_q;
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 ferr_q, ferr_d;
    logic                 overrun_q, overrun_d;
    logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];

    logic push, push_en, pop, full, empty;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        ferr_d  = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rxs_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HalfM1) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A start bit gone high by mid-bit is treated as a glitch.
                    state_d = rxs_q ? StIdle : StData;
                end
            end
            StData: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BitM1) begin
                    cnt_d   = '0;
                    shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LastIdx) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BitM1) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StBreak;
                    end
                end
            end
            StBreak: begin
                if (rxs_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = !empty && io_rx_ready;
    assign push_en = push && (!full || pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_en) begin
            mem_d[wr_ptr_q[AW-1:0]] = shift_q;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        overrun_d = overrun_q;
        if (io_clearErrors) begin
            overrun_d = 1'b0;
        end
        if (push && full && !pop) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge io_clock) begin
        if (!io_reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rx_meta_q <= io_uartStd_rxd;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            ferr_q    <= ferr_d;
            overrun_q <= overrun_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            mem_q     <= mem_d;
        end
    end

    assign io_rx_valid   = !empty;
    assign io_rx_payload = mem_q[rd_ptr_q[AW-1:0]];
    assign io_occupancy  = wr_ptr_q - rd_ptr_q;
    assign io_frameError = ferr_q;
    assign io_overrun    = overrun_q;

endmodule

// File: tb/tb_uart_std_rx.sv
// Directed bench for uart_std_rx at 16 clocks per bit: table of frames plus
// hand-written overrun, break, glitch, full-FIFO and mid-frame reset sequences.
module tb_uart_std_rx;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic       ready;
    logic       clr;
    logic       valid;
    logic [7:0] payload;
    logic [2:0] occ;
    logic       ferr;
    logic       overrun;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] rx_q [$];
    int         ferr_cnt = 0;

    uart_std_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8),
        .FIFO_DEPTH  (4)
    ) dut (
        .io_clock      (clk),
        .io_reset      (rst_n),
        .io_uartStd_rxd(rxd),
        .io_rx_valid   (valid),
        .io_rx_ready   (ready),
        .io_rx_payload (payload),
        .io_occupancy  (occ),
        .io_frameError (ferr),
        .io_overrun    (overrun),
        .io_clearErrors(clr)
    );

    always #5 clk = ~clk;

    // Records every accepted beat and every cycle frameError is high.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && ready) rx_q.push_back(payload);
            if (ferr) ferr_cnt++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Leaves rxd at the stop-bit level; callers restore idle.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        @(posedge clk);
        #1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic drain(input int cycles);
        @(posedge clk);
        #1 ready = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 ready = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        int         exp_beat;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int nb;
        int nf;

        vecs[0] = '{8'h55, 1'b1, 0,  1, 8'h55, 0};
        vecs[1] = '{8'hA3, 1'b1, 4,  1, 8'hA3, 0};
        vecs[2] = '{8'h00, 1'b1, 0,  1, 8'h00, 0};
        vecs[3] = '{8'hFF, 1'b1, 4,  1, 8'hFF, 0};
        vecs[4] = '{8'h33, 1'b0, 20, 0, 8'h00, 1};
        vecs[5] = '{8'h80, 1'b1, 4,  1, 8'h80, 0};
        vecs[6] = '{8'h01, 1'b1, 4,  1, 8'h01, 0};

        rst_n = 1'b0;
        rxd   = 1'b1;
        ready = 1'b0;
        clr   = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset valid", valid, 0);
        check("reset payload", payload, 0);
        check("reset occupancy", occ, 0);
        check("reset frameError", ferr, 0);
        check("reset overrun", overrun, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Table-driven frames with the consumer always ready.
        ready = 1'b1;
        foreach (vecs[k]) begin
            nb = rx_q.size();
            nf = ferr_cnt;
            send_frame(vecs[k].data, vecs[k].stop);
            rxd = 1'b1;
            repeat (vecs[k].gap) @(posedge clk);
            #1;
            check($sformatf("vec%0d beats", k), rx_q.size() - nb, vecs[k].exp_beat);
            if (vecs[k].exp_beat != 0 && rx_q.size() > nb)
                check($sformatf("vec%0d payload", k), rx_q[$], vecs[k].exp_data);
            check($sformatf("vec%0d frameError", k), ferr_cnt - nf, vecs[k].exp_ferr);
            check($sformatf("vec%0d overrun", k), overrun, 0);
        end
        check("table occupancy", occ, 0);

        // Overrun: five characters into a four-entry FIFO with no consumer.
        ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            repeat (4) @(posedge clk);
        end
        @(negedge clk);
        check("ovr occupancy", occ, 4);
        check("ovr flag", overrun, 1);
        check("ovr valid", valid, 1);
        check("ovr head", payload, 8'h01);
        rx_q.delete();
        drain(6);
        @(negedge clk);
        check("ovr drained count", rx_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("ovr drain%0d", i), (i < rx_q.size()) ? int'(rx_q[i]) : -1, i + 1);
        check("ovr empty occupancy", occ, 0);
        check("ovr sticky", overrun, 1);
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check("ovr cleared", overrun, 0);

        // Stop bit low followed by a long break: exactly one frameError cycle.
        ready = 1'b1;
        rx_q.delete();
        nf = ferr_cnt;
        send_frame(8'h7E, 1'b0);
        repeat (40 * CPB) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        check("break frameError cycles", ferr_cnt - nf, 1);
        check("break no push", rx_q.size(), 0);
        send_frame(8'h42, 1'b1);
        repeat (4) @(posedge clk);
        check("after break count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("after break payload", rx_q[0], 8'h42);

        // Four-cycle low glitch on the idle line.
        rx_q.delete();
        nf = ferr_cnt;
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (4) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        @(negedge clk);
        check("glitch valid", valid, 0);
        check("glitch beats", rx_q.size(), 0);
        check("glitch frameError", ferr_cnt - nf, 0);
        send_frame(8'h3C, 1'b1);
        repeat (4) @(posedge clk);
        check("after glitch count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("after glitch payload", rx_q[0], 8'h3C);

        // Full FIFO: pop lands in the same cycle as the stop-bit sample.
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_frame(8'h10 + 8'(i), 1'b1);
            repeat (4) @(posedge clk);
        end
        @(negedge clk);
        check("full occupancy", occ, 4);
        rx_q.delete();
        fork
            begin
                send_frame(8'h14, 1'b1);
            end
            begin
                // Stop sample occurs in the cycle ending at the 155th edge after frame start.
                @(posedge clk);
                repeat (154) @(posedge clk);
                #1 ready = 1'b1;
                @(posedge clk);
                #1 ready = 1'b0;
            end
        join
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("coincide occupancy", occ, 4);
        check("coincide overrun", overrun, 0);
        check("coincide popped", (rx_q.size() > 0) ? int'(rx_q[0]) : -1, 8'h10);
        check("coincide head", payload, 8'h11);
        rx_q.delete();
        drain(6);
        @(negedge clk);
        check("coincide drained count", rx_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("coincide drain%0d", i),
                  (i < rx_q.size()) ? int'(rx_q[i]) : -1, 8'h11 + i);

        // Reset pulse during data bit 3 with a character waiting in the FIFO.
        send_frame(8'h99, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("prereset occupancy", occ, 1);
        check("prereset payload", payload, 8'h99);
        @(posedge clk);
        #1 rxd = 1'b0;
        repeat (CPB) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (3 * CPB + 6) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midreset valid", valid, 0);
        check("midreset payload", payload, 0);
        check("midreset occupancy", occ, 0);
        check("midreset frameError", ferr, 0);
        check("midreset overrun", overrun, 0);
        nf = ferr_cnt;
        repeat (8 * CPB) @(posedge clk);
        check("midreset no frameError", ferr_cnt - nf, 0);
        ready = 1'b1;
        rx_q.delete();
        send_frame(8'hC6, 1'b1);
        repeat (4) @(posedge clk);
        check("postreset count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("postreset payload", rx_q[0], 8'hC6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
